alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
Upstream command stage for the 8-bit registered ALU. It accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO. It presents each command to the ALU on registered operand/opcode lines and captures the ALU's registered result. It then returns {result, opcode, tag} over a valid/ready response interface, in order, one command in flight at a time.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2.
TAG_W, 4, width of the user tag carried from command to response.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  command valid.
in_ready  output  1  command ready = reset && (count != DEPTH).
in_opA  input  8  operand A.
in_opB  input  8  operand B.
in_opcode  input  3  ALU opcode.
in_tag  input  TAG_W  user tag.
alu_opA  output  8  registered operand A to ALU.
alu_opB  output  8  registered operand B to ALU.
alu_opcode  output  3  registered opcode to ALU.
alu_result  input  8  ALU registered output.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response consumer ready.
rsp_result  output  8  captured ALU result.
rsp_opcode  output  3  opcode of the completed command.
rsp_tag  output  TAG_W  tag of the completed command.
busy  output  1  high when state != IDLE or count != 0.

Behaviour:
- Reset (reset=0, async):
  - FIFO count, read pointer and write pointer are cleared to 0; state goes to IDLE.
  - alu_opA, alu_opB and alu_opcode are cleared to 0; rsp_* are cleared to 0; rsp_valid=0; busy=0.
  - in_ready is forced to 0 while reset=0.
  - A mid-operation reset discards all buffered and in-flight commands; no response is produced for them.
- Push: occurs on in_valid && in_ready; the entry {opA, opB, opcode, tag} is written at the write pointer.
  - in_ready depends only on count, so no push is accepted while full, even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
  - A push and a pop in the same cycle leave count unchanged.
- ALU timing contract: the ALU samples alu_* on edge N and presents alu_result after edge N; alu_result is captured on edge N+1.
- FSM states: IDLE, WAIT, CAPT, RESP.
  - IDLE: if count != 0, pop the head entry, load alu_opA/alu_opB/alu_opcode, latch opcode and tag internally, go to WAIT. Otherwise stay in IDLE.
  - WAIT: go to CAPT (the ALU registers its result on this edge).
  - CAPT: rsp_result <= alu_result, rsp_opcode/rsp_tag <= latched values, rsp_valid <= 1, go to RESP.
  - RESP: if rsp_ready:
    - rsp_valid <= 0.
    - If count != 0, pop and load the next command into alu_* on the same edge and go to WAIT (back-to-back).
    - Otherwise go to IDLE.
  - RESP without rsp_ready: hold all rsp_* stable.
- alu_* outputs hold their last value until the next load; they are not cleared after use.
- Latency: a command pushed on edge E0 into an empty, idle block is popped at E1 and raises rsp_valid after E3, i.e. 3 cycles.
  - Back-to-back throughput is one response per 3 cycles when rsp_ready is held high.
- Push into an empty FIFO while in IDLE: the pop occurs on the following edge, never the same edge, so there is no bypass.
- Responses leave in acceptance order; tags are passed through unmodified.
- rsp_valid, once raised, stays high until the cycle in which rsp_ready=1 (no retraction).
- The result is the ALU's 8-bit value unmodified; no width extension or checking is done here.

Test Plan:
- Single ADD: push opA=8'h05, opB=8'h03, opcode=3'b000, tag=4'h1 with rsp_ready=1 -> rsp_valid high 3 cycles after acceptance, rsp_result=8'h08, rsp_opcode=3'b000, rsp_tag=4'h1, for one cycle. The bench drives alu_result from an 8-bit ALU model with one-cycle registered latency.
- Truncation/ordering: push MUL 8'h10*8'h10 (tag 2), then SUB 8'h03-8'h05 (tag 3) -> responses 8'h00 (tag 2), then 8'hFE (tag 3), in order, 3 cycles apart.
- Fill/full: rsp_ready=0, push 1+DEPTH=5 commands -> the first enters flight, the next 4 fill the FIFO, in_ready=0 at count=4, and a 6th in_valid is not accepted. Release rsp_ready -> all 5 responses arrive in order; in_ready returns high after the first pop.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_result and rsp_tag remain stable; on rsp_ready=1, exactly one handshake occurs and busy falls once the FIFO is empty.
- Reset mid-operation: assert reset=0 during WAIT with 2 entries queued -> immediately rsp_valid=0, alu_*=0, busy=0, in_ready=0. After release, in_ready=1 and no stale responses ever appear.
- Pointer wrap: stream 10 commands with tags 0..9 under random rsp_ready -> tags emerge 0..9 in order with correct XOR/EQ/SHL results, e.g. EQ 8'hAA,8'hAA -> 8'h01; SHL 8'h01<<3 -> 8'h08.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response buses for the ALU command sequencer.
// The slave side is the sequencer; the master side is the command source, ALU and response sink.
interface alu_cmd_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_opA;
    logic [7:0]       in_opB;
    logic [2:0]       in_opcode;
    logic [TAG_W-1:0] in_tag;

    logic [7:0]       alu_opA;
    logic [7:0]       alu_opB;
    logic [2:0]       alu_opcode;
    logic [7:0]       alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_result;
    logic [2:0]       rsp_opcode;
    logic [TAG_W-1:0] rsp_tag;

    modport slave (
        input  in_valid, in_opA, in_opB, in_opcode, in_tag, alu_result, rsp_ready,
        output in_ready, alu_opA, alu_opB, alu_opcode,
               rsp_valid, rsp_result, rsp_opcode, rsp_tag
    );

    modport master (
        output in_valid, in_opA, in_opB, in_opcode, in_tag, alu_result, rsp_ready,
        input  in_ready, alu_opA, alu_opB, alu_opcode,
               rsp_valid, rsp_result, rsp_opcode, rsp_tag
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO and runs them one at a time through a registered ALU.
// Push to rsp_valid is 3 cycles; in_ready drops when full, rsp_* hold while rsp_ready is low.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_cmd_sequencer_if.slave   cmd_if,
    output logic                 busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [7:0]       op_a;
        logic [7:0]       op_b;
        logic [2:0]       opcode;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WAIT, CAPT, RESP} state_t;

    cmd_t             mem_q [DEPTH];
    cmd_t             in_cmd;
    cmd_t             head;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [7:0]       alu_op_a_q, alu_op_a_d;
    logic [7:0]       alu_op_b_q, alu_op_b_d;
    logic [2:0]       alu_opcode_q, alu_opcode_d;
    logic [2:0]       lat_opcode_q, lat_opcode_d;
    logic [TAG_W-1:0] lat_tag_q, lat_tag_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic [2:0]       rsp_opcode_q, rsp_opcode_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    logic             push;
    logic             pop;
    logic             fifo_empty;

    // in_ready looks only at count, so a simultaneous pop never frees a slot early
    assign cmd_if.in_ready = reset && (count_q != CNT_W'(DEPTH));
    assign push            = cmd_if.in_valid && cmd_if.in_ready;
    assign fifo_empty      = (count_q == '0);
    assign in_cmd          = {cmd_if.in_opA, cmd_if.in_opB, cmd_if.in_opcode, cmd_if.in_tag};
    assign head            = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_cmd;
        end
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        alu_op_a_d   = alu_op_a_q;
        alu_op_b_d   = alu_op_b_q;
        alu_opcode_d = alu_opcode_q;
        lat_opcode_d = lat_opcode_q;
        lat_tag_d    = lat_tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_opcode_d = rsp_opcode_q;
        rsp_tag_d    = rsp_tag_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: state_d = CAPT;
            CAPT: begin
                rsp_valid_d  = 1'b1;
                rsp_result_d = cmd_if.alu_result;
                rsp_opcode_d = lat_opcode_q;
                rsp_tag_d    = lat_tag_q;
                state_d      = RESP;
            end
            RESP: begin
                if (cmd_if.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop always launches the head command into the ALU on the same edge
        if (pop) begin
            alu_op_a_d   = head.op_a;
            alu_op_b_d   = head.op_b;
            alu_opcode_d = head.opcode;
            lat_opcode_d = head.opcode;
            lat_tag_d    = head.tag;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_op_a_q   <= '0;
            alu_op_b_q   <= '0;
            alu_opcode_q <= '0;
            lat_opcode_q <= '0;
            lat_tag_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_opcode_q <= '0;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            alu_op_a_q   <= alu_op_a_d;
            alu_op_b_q   <= alu_op_b_d;
            alu_opcode_q <= alu_opcode_d;
            lat_opcode_q <= lat_opcode_d;
            lat_tag_q    <= lat_tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_opcode_q <= rsp_opcode_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign cmd_if.alu_opA    = alu_op_a_q;
    assign cmd_if.alu_opB    = alu_op_b_q;
    assign cmd_if.alu_opcode = alu_opcode_q;
    assign cmd_if.rsp_valid  = rsp_valid_q;
    assign cmd_if.rsp_result = rsp_result_q;
    assign cmd_if.rsp_opcode = rsp_opcode_q;
    assign cmd_if.rsp_tag    = rsp_tag_q;
    assign busy              = (state_q != IDLE) || !fifo_empty;
endmodule
